// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter: ALU/load results to a single registered register-file write port
module wb_arbiter #(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [31:0]     alu_instr,
  input  logic [XLEN-1:0] alu_result,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [31:0]     mem_instr,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [2:0]      mem_addr_lo,
  output logic            rf_write,
  output logic [31:0]     rf_instr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            wb_misaligned
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0]      r_starve_cnt;
  logic            r_write;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_wdata;
  logic            r_misaligned;

  logic            w_alu_grant;
  logic            w_mem_grant;
  logic [2:0]      w_funct3;
  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_load_data;
  logic            w_load_bad;

  // Loads win contention until the ALU has waited LIMIT cycles in a row.
  assign w_alu_grant = !rst && alu_valid && (!mem_valid || (r_starve_cnt == LIMIT));
  assign w_mem_grant = !rst && mem_valid && !w_alu_grant;
  assign alu_ready   = w_alu_grant;
  assign mem_ready   = w_mem_grant;

  assign w_funct3  = mem_instr[14:12];
  assign w_shifted = mem_rdata >> {mem_addr_lo, 3'b000};

  always_comb begin
    w_load_data = '0;
    w_load_bad  = 1'b0;
    case (w_funct3)
      3'b000: w_load_data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      3'b100: w_load_data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      3'b001: begin
        w_load_data = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
        w_load_bad  = mem_addr_lo[0];
      end
      3'b101: begin
        w_load_data = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
        w_load_bad  = mem_addr_lo[0];
      end
      3'b010: begin
        w_load_data = {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
        w_load_bad  = (mem_addr_lo[1:0] != 2'b00);
      end
      3'b110: begin
        w_load_data = {{(XLEN-32){1'b0}}, w_shifted[31:0]};
        w_load_bad  = (mem_addr_lo[1:0] != 2'b00);
      end
      3'b011: begin
        w_load_data = mem_rdata;
        w_load_bad  = (mem_addr_lo != 3'b000);
      end
      default: w_load_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (!alu_valid || w_alu_grant) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  // Writes to x0 are accepted and forwarded, but never enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_instr      <= '0;
      r_wdata      <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_write      <= 1'b0;
      r_misaligned <= 1'b0;
      if (w_alu_grant) begin
        r_instr <= alu_instr;
        r_wdata <= alu_result;
        r_write <= (alu_instr[11:7] != 5'd0);
      end else if (w_mem_grant) begin
        r_instr <= mem_instr;
        if (w_load_bad) begin
          r_wdata      <= '0;
          r_misaligned <= 1'b1;
        end else begin
          r_wdata <= w_load_data;
          r_write <= (mem_instr[11:7] != 5'd0);
        end
      end
    end
  end

  assign rf_write      = r_write;
  assign rf_instr      = r_instr;
  assign rf_wdata      = r_wdata;
  assign wb_misaligned = r_misaligned;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed self-checking bench for wb_arbiter
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready, mem_valid, mem_ready;
  logic [31:0] alu_instr, mem_instr, rf_instr;
  logic [63:0] alu_result, mem_rdata, rf_wdata;
  logic [2:0]  mem_addr_lo;
  logic        rf_write, wb_misaligned;

  int checks   = 0;
  int failures = 0;

  wb_arbiter #(.XLEN(64), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_instr(alu_instr), .alu_result(alu_result),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr), .mem_rdata(mem_rdata),
    .mem_addr_lo(mem_addr_lo),
    .rf_write(rf_write), .rf_instr(rf_instr), .rf_wdata(rf_wdata), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] RDATA = 64'h8877665544332211;
  localparam logic [31:0] LD_X2 = 32'h00013103;
  localparam logic [31:0] ALU_X2 = 32'h00300113;

  logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b110, 3'b011};
  logic [2:0]  ld_b   [5] = '{3'd7, 3'd7, 3'd6, 3'd4, 3'd0};
  logic [63:0] ld_exp [5] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'hFFFFFFFFFFFF8877,
                              64'h88776655, 64'h8877665544332211};
  logic [2:0]  bad_f3 [2] = '{3'b010, 3'b111};
  logic [2:0]  bad_b  [2] = '{3'd2, 3'd0};

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_instr = '0; alu_result = '0;
    mem_valid = 1'b0; mem_instr = '0; mem_rdata = '0; mem_addr_lo = '0;
    tick();
    tick();
    check("rst_rf_write", rf_write, 0);
    check("rst_rf_instr", rf_instr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_misaligned", wb_misaligned, 0);
    check("rst_starve", dut.r_starve_cnt, 0);
    rst = 1'b0;

    alu_valid = 1'b1; alu_instr = 32'h00500093; alu_result = 64'd5;
    #1;
    check("alu_ready", alu_ready, 1);
    check("alu_mem_ready", mem_ready, 0);
    tick();
    alu_valid = 1'b0;
    check("alu_rf_write", rf_write, 1);
    check("alu_rf_instr", rf_instr, 32'h00500093);
    check("alu_rf_wdata", rf_wdata, 5);

    mem_rdata = RDATA;
    for (int i = 0; i < 5; i++) begin
      mem_valid = 1'b1; mem_instr = {17'd0, ld_f3[i], 12'h183}; mem_addr_lo = ld_b[i];
      #1;
      check($sformatf("ld%0d_ready", i), mem_ready, 1);
      tick();
      check($sformatf("ld%0d_wdata", i), rf_wdata, ld_exp[i]);
      check($sformatf("ld%0d_write", i), rf_write, 1);
      check($sformatf("ld%0d_misal", i), wb_misaligned, 0);
    end

    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1; mem_instr = {17'd0, bad_f3[i], 12'h183}; mem_addr_lo = bad_b[i];
      #1;
      check($sformatf("bad%0d_ready", i), mem_ready, 1);
      tick();
      mem_valid = 1'b0;
      check($sformatf("bad%0d_write", i), rf_write, 0);
      check($sformatf("bad%0d_misal", i), wb_misaligned, 1);
      check($sformatf("bad%0d_wdata", i), rf_wdata, 0);
      tick();
      check($sformatf("bad%0d_pulse_end", i), wb_misaligned, 0);
    end

    alu_valid = 1'b1; alu_instr = 32'h00700013; alu_result = 64'd7;
    #1;
    check("x0_ready", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check("x0_write", rf_write, 0);
    check("x0_instr", rf_instr, 32'h00700013);
    check("x0_wdata", rf_wdata, 7);

    alu_valid = 1'b1; alu_instr = ALU_X2; alu_result = 64'h33;
    mem_valid = 1'b1; mem_instr = LD_X2; mem_addr_lo = 3'd0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check($sformatf("cont%0d_starve", i), dut.r_starve_cnt, (i == 5) ? 0 : i);
      check($sformatf("cont%0d_alu_ready", i), alu_ready, (i == 4) ? 1 : 0);
      check($sformatf("cont%0d_mem_ready", i), mem_ready, (i == 4) ? 0 : 1);
      tick();
      check($sformatf("cont%0d_instr", i), rf_instr, (i == 4) ? ALU_X2 : LD_X2);
      check($sformatf("cont%0d_wdata", i), rf_wdata, (i == 4) ? 64'h33 : RDATA);
    end
    check("cont_starve_after", dut.r_starve_cnt, 1);

    rst = 1'b1;
    #1;
    check("mrst_alu_ready", alu_ready, 0);
    check("mrst_mem_ready", mem_ready, 0);
    tick();
    check("mrst_write", rf_write, 0);
    check("mrst_instr", rf_instr, 0);
    check("mrst_wdata", rf_wdata, 0);
    check("mrst_misal", wb_misaligned, 0);
    check("mrst_starve", dut.r_starve_cnt, 0);
    rst = 1'b0;
    #1;
    check("post_mem_ready", mem_ready, 1);
    check("post_alu_ready", alu_ready, 0);
    tick();
    check("post_instr", rf_instr, LD_X2);
    check("post_write", rf_write, 1);
    check("post_starve", dut.r_starve_cnt, 1);

    alu_valid = 1'b0; mem_valid = 1'b0;
    tick();
    check("idle_write", rf_write, 0);
    check("idle_hold_wdata", rf_wdata, RDATA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
